// File: rtl/msk_rnd_gen.sv
`default_nettype none
// ============================================================================
// Module      : msk_rnd_gen
// Description : Seeded 32-bit LFSR supplying fresh randomness to masked gadgets
//               with seed handshake, warm-up discard and valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module msk_rnd_gen #(
    parameter int d    = 2,
    parameter int NRND = 2,
    parameter int WARM = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     seed_i,
    input  logic            seed_valid_i,
    output logic            seed_ready_o,
    output logic [NRND-1:0] rnd_o,
    output logic            rnd_valid_o,
    input  logic            rnd_ready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [7:0] WARM_LOAD = (WARM > 0) ? 8'(WARM - 1) : 8'd0;
    localparam bit         CFG_OK    = (NRND >= 1) && (NRND <= 32) &&
                                       (WARM >= 0) && (WARM <= 255) && (d >= 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("msk_rnd_gen: parameter out of legal range");
        end
    endgenerate

    state_e      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        seed_hs;

    function automatic logic [31:0] advance(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < NRND; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    assign seed_ready_o = (state_q != WARMUP);
    assign seed_hs      = seed_valid_i && seed_ready_o;
    assign rnd_valid_o  = (state_q == RUN);
    assign rnd_o        = lfsr_q[NRND-1:0];

    // A seed load always takes priority over a coincident consume in RUN.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        if (seed_hs) begin
            lfsr_d  = (seed_i == 32'd0) ? 32'h0000_0001 : seed_i;
            cnt_d   = WARM_LOAD;
            state_d = (WARM > 0) ? WARMUP : RUN;
        end else begin
            case (state_q)
                WARMUP: begin
                    lfsr_d = advance(lfsr_q);
                    if (cnt_q == 8'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                RUN: begin
                    if (rnd_ready_i) begin
                        lfsr_d = advance(lfsr_q);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msk_rnd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_msk_rnd_gen
// Description : Self-checking bench for msk_rnd_gen (directed + randomized).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msk_rnd_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // dut0: WARM=0, NRND=2
    logic [31:0] seed0 = '0;
    logic        sv0 = 1'b0, rr0 = 1'b0, sr0, rv0;
    logic [1:0]  rnd0;
    // dut4: WARM=4, NRND=2
    logic [31:0] seed4 = '0;
    logic        sv4 = 1'b0, rr4 = 1'b0, sr4, rv4;
    logic [1:0]  rnd4;
    // dut5: WARM=5, NRND=7
    localparam int R_WARM = 5;
    localparam int R_NRND = 7;
    logic [31:0] seed5 = '0;
    logic        sv5 = 1'b0, rr5 = 1'b0, sr5, rv5;
    logic [R_NRND-1:0] rnd5;

    msk_rnd_gen #(.d(2), .NRND(2), .WARM(0)) dut0 (
        .clk(clk), .rst(rst), .seed_i(seed0), .seed_valid_i(sv0), .seed_ready_o(sr0),
        .rnd_o(rnd0), .rnd_valid_o(rv0), .rnd_ready_i(rr0));
    msk_rnd_gen #(.d(2), .NRND(2), .WARM(4)) dut4 (
        .clk(clk), .rst(rst), .seed_i(seed4), .seed_valid_i(sv4), .seed_ready_o(sr4),
        .rnd_o(rnd4), .rnd_valid_o(rv4), .rnd_ready_i(rr4));
    msk_rnd_gen #(.d(3), .NRND(R_NRND), .WARM(R_WARM)) dut5 (
        .clk(clk), .rst(rst), .seed_i(seed5), .seed_valid_i(sv5), .seed_ready_o(sr5),
        .rnd_o(rnd5), .rnd_valid_o(rv5), .rnd_ready_i(rr5));

    // Reference: n LFSR steps of the feedback polynomial taps 31,21,1,0.
    function automatic logic [31:0] lfsr_n(input logic [31:0] s, input int n);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < n; i++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sv0 = 0; rr0 = 0; sv4 = 0; rr4 = 0; sv5 = 0; rr5 = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if (rv0 !== 1'b0 || rnd0 !== 2'b00 || rv4 !== 1'b0 || rnd4 !== 2'b00 || rv5 !== 1'b0 || rnd5 !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rv0=%b rnd0=%b rv4=%b rnd4=%b rv5=%b rnd5=%h required all 0",
                     rv0, rnd0, rv4, rnd4, rv5, rnd5);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (sr0 !== 1'b1 || sr4 !== 1'b1 || sr5 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_seed_ready: sr0=%b sr4=%b sr5=%b required 1", sr0, sr4, sr5);
        end
    endtask

    task automatic test_idle_ready_ignored();
        rr0 = 1'b1; rr4 = 1'b1;
        tick(); tick(); tick();
        tests_run++;
        if (rv0 !== 1'b0 || rnd0 !== 2'b00 || rv4 !== 1'b0 || rnd4 !== 2'b00 || sr4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_ready_ignored: rv0=%b rnd0=%b rv4=%b rnd4=%b sr4=%b required 0,00,0,00,1",
                     rv0, rnd0, rv4, rnd4, sr4);
        end
        rr0 = 1'b0; rr4 = 1'b0;
    endtask

    task automatic run_warm0_seq(input logic [31:0] sd, input string nm);
        logic [1:0] exp [3];
        exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b11;
        do_reset();
        seed0 = sd; sv0 = 1'b1;
        tick();
        sv0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rv0 !== 1'b1 || rnd0 !== exp[i]) begin
                tests_failed++;
                $display("FAIL %s_word%0d: rv=%b rnd=%b required rv=1 rnd=%b", nm, i, rv0, rnd0, exp[i]);
            end
            rr0 = 1'b1;
            tick();
            rr0 = 1'b0;
        end
    endtask

    task automatic test_warm0_seq();
        run_warm0_seq(32'h0000_0001, "seed1");
    endtask

    task automatic test_zero_seed();
        run_warm0_seq(32'h0000_0000, "seed0");
    endtask

    task automatic test_stall();
        do_reset();
        seed0 = 32'h1; sv0 = 1'b1;
        tick();
        sv0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (rv0 !== 1'b1 || rnd0 !== 2'b01) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: rv=%b rnd=%b required rv=1 rnd=01", i, rv0, rnd0);
            end
        end
        rr0 = 1'b1;
        tick();
        rr0 = 1'b0;
        tests_run++;
        if (rv0 !== 1'b1 || rnd0 !== 2'b10) begin
            tests_failed++;
            $display("FAIL stall_release: rv=%b rnd=%b required rv=1 rnd=10", rv0, rnd0);
        end
    endtask

    // Seeds dut4 and checks the 4-cycle warm-up window and first word.
    task automatic warmup_check(input logic [31:0] sd, input string nm);
        logic [31:0] e;
        e = lfsr_n(sd, 4 * 2);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rv4 !== 1'b0 || sr4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_window%0d: rv=%b sr=%b required rv=0 sr=0", nm, i, rv4, sr4);
            end
            tick();
        end
        tests_run++;
        if (rv4 !== 1'b1 || sr4 !== 1'b1 || rnd4 !== e[1:0]) begin
            tests_failed++;
            $display("FAIL %s_first: rv=%b sr=%b rnd=%b required rv=1 sr=1 rnd=%b", nm, rv4, sr4, rnd4, e[1:0]);
        end
    endtask

    task automatic test_warmup();
        logic [31:0] sd;
        do_reset();
        sd = $urandom();
        seed4 = sd; sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
        warmup_check(sd, "warmup");
    endtask

    task automatic test_reseed_run();
        logic [31:0] sd;
        sd = $urandom() | 32'h4;
        seed4 = sd; sv4 = 1'b1; rr4 = 1'b1;
        tick();
        sv4 = 1'b0;
        tests_run++;
        if (rnd4 !== sd[1:0] || rv4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reseed_load: rnd=%b rv=%b required rnd=%b rv=0", rnd4, rv4, sd[1:0]);
        end
        warmup_check(sd, "reseed");
        rr4 = 1'b0;
    endtask

    task automatic test_async_rst();
        do_reset();
        seed4 = 32'hDEAD_BEEF; sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (rv4 !== 1'b0 || rnd4 !== 2'b00 || sr4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_rst_now: rv=%b rnd=%b sr=%b required 0,00,1", rv4, rnd4, sr4);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (rv4 !== 1'b0 || rnd4 !== 2'b00) begin
                tests_failed++;
                $display("FAIL async_rst_noseed%0d: rv=%b rnd=%b required 0,00", i, rv4, rnd4);
            end
        end
        seed4 = 32'h1234_5678; sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
        warmup_check(32'h1234_5678, "post_rst");
    endtask

    task automatic test_random();
        logic [31:0] ms;
        bit          seeded;
        int          warm_left;
        bit          in_warm, in_run;
        logic [31:0] sd;
        bit          svb, rrb;
        do_reset();
        ms = '0; seeded = 0; warm_left = 0;
        for (int c = 0; c < 400; c++) begin
            svb = ($urandom_range(0, 9) == 0);
            rrb = ($urandom_range(0, 2) != 0);
            sd  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            seed5 = sd; sv5 = svb; rr5 = rrb;
            in_warm = seeded && warm_left > 0;
            in_run  = seeded && warm_left == 0;
            if (svb && !in_warm) begin
                ms = (sd == 0) ? 32'h1 : sd;
                seeded = 1;
                warm_left = R_WARM;
            end else if (in_warm) begin
                ms = lfsr_n(ms, R_NRND);
                warm_left--;
            end else if (in_run && rrb) begin
                ms = lfsr_n(ms, R_NRND);
            end
            tick();
            in_warm = seeded && warm_left > 0;
            in_run  = seeded && warm_left == 0;
            tests_run++;
            if (rnd5 !== ms[R_NRND-1:0] || rv5 !== in_run || sr5 !== !in_warm) begin
                tests_failed++;
                $display("FAIL random_c%0d: rnd=%h rv=%b sr=%b required rnd=%h rv=%b sr=%b",
                         c, rnd5, rv5, sr5, ms[R_NRND-1:0], in_run, !in_warm);
            end
        end
        sv5 = 1'b0; rr5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_ready_ignored();
        test_warm0_seq();
        test_zero_seed();
        test_stall();
        test_warmup();
        test_reseed_run();
        test_async_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msk_rnd_gen.md
MSK_RND_GEN -- requirements
Module: msk_rnd_gen

Interface
REQ-001 SHALL have parameter d, default 2, share count of the masked gadgets it feeds (informational; does not change behaviour).
REQ-002 SHALL have parameter NRND, default 2, fresh random bits delivered per transfer; legal range 1..32.
REQ-003 SHALL have parameter WARM, default 64, warm-up cycles discarded after each seed load; legal range 0..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 seed  input  32  seed word for the LFSR state.
REQ-007 seed_valid  input  1  seed word present.
REQ-008 seed_ready  output  1  block accepts a seed this cycle.
REQ-009 rnd  output  NRND  random bits for the downstream gadget randomness port.
REQ-010 rnd_valid  output  1  rnd holds fresh, unconsumed bits.
REQ-011 rnd_ready  input  1  consumer takes rnd this cycle.

Function
REQ-012 SHALL hold a 32-bit LFSR state S; one step: b = S[31]^S[21]^S[1]^S[0], S <= {S[30:0], b}.
REQ-013 An "advance" SHALL apply NRND consecutive steps within one clock cycle.
REQ-014 rnd SHALL equal S[NRND-1:0] combinationally from the state register in every state.
REQ-015 FSM states SHALL be IDLE, WARMUP and RUN.
REQ-016 A seed handshake SHALL occur on a rising edge with seed_valid=1 and seed_ready=1.
REQ-017 seed_ready SHALL be 1 in IDLE and RUN and 0 in WARMUP.
REQ-018 On a seed handshake, S SHALL load seed, or 32'h00000001 if seed is zero (lock-up avoidance).
REQ-019 On a seed handshake, the warm-up counter SHALL load WARM-1 and the FSM SHALL go to WARMUP if WARM>0, otherwise to RUN.
REQ-020 In WARMUP, S SHALL advance every cycle and the counter SHALL decrement; on the cycle the counter is 0, the FSM SHALL go to RUN (exactly WARM advances).
REQ-021 rnd_valid SHALL be 1 only in RUN.
REQ-022 In RUN, S SHALL advance on a rising edge with rnd_ready=1 and SHALL hold when rnd_ready=0, so a stalled word is never altered.
REQ-023 When a seed handshake and rnd_ready=1 coincide in RUN, the seed load SHALL win, the current word counts as consumed, and no advance is applied.
REQ-024 A reseed from RUN SHALL drop rnd_valid on the next cycle when WARM>0.
REQ-025 No word SHALL be presented twice: each RUN handshake is followed by a new advance.
REQ-026 rnd_ready while rnd_valid=0 SHALL be ignored.

Reset
REQ-027 rst=1 SHALL asynchronously force S=0, FSM=IDLE, counter=0, rnd_valid=0 and rnd=0, with seed_ready=1 once rst is released.
REQ-028 Asserting rst mid-WARMUP or mid-RUN SHALL abandon the operation; after release a new seed is required before rnd_valid rises.
REQ-029 Outputs SHALL be stable at reset values while rst is high, independent of clk.

Verification
REQ-030 WARM=0, NRND=2, seed=32'h1 accepted -> next cycle rnd_valid=1 and rnd=2'b01; after one consume rnd=2'b10 (S=0x6); after another rnd=2'b11 (S=0x1B).
REQ-031 WARM=0, seed=32'h0 -> same sequence as seed=32'h1 (2'b01, 2'b10, 2'b11).
REQ-032 WARM=0, rnd_ready held 0 for 5 cycles in RUN -> rnd stays 2'b01 and rnd_valid stays 1; the first consume yields 2'b10.
REQ-033 WARM=4, seed accepted at edge k -> seed_ready=0 and rnd_valid=0 for 4 cycles; rnd_valid=1 after edge k+4; rnd equals the low bits of S after 4 advances (reference model).
REQ-034 WARM=4: reseed in RUN with rnd_ready=1 on the same edge -> S equals the new seed, no advance applied, rnd_valid=0 for 4 cycles.
REQ-035 rst pulse mid-WARMUP (async, between edges) -> rnd_valid=0 and rnd=0 immediately; rnd_valid stays 0 until a new seed and warm-up complete.
